rbb_drain: RTL and testbench

RBB_DRAIN -- requirements
Module: rbb_drain

---
 rtl/rbb_drain.sv | 140 ++++++++++++++
 tb/tb_rbb_drain.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rbb_drain.sv
// Drains result batch buffers one batch at a time to a host write port.
// Buffers are granted round-robin, read at one line per cycle through a 2-entry skid FIFO.
module rbb_drain #(
   parameter int NUM_RBB         = 4,
   parameter int RBB_ADDR_WIDTH  = 4,
   parameter int RBB_DATA_WIDTH  = 512,
   parameter int NUM_LINES       = 16,
   parameter int HOST_ADDR_WIDTH = 32
) (
   input  logic                               clk,
   input  logic                               reset_n,
   input  logic [NUM_RBB-1:0]                 rbb_request,
   output logic [NUM_RBB-1:0]                 rbb_rden,
   output logic [RBB_ADDR_WIDTH-1:0]          rbb_rdaddr,
   input  logic [NUM_RBB*RBB_DATA_WIDTH-1:0]  rbb_rddout,
   input  logic [HOST_ADDR_WIDTH-1:0]         base_addr,
   output logic                               wr_valid,
   input  logic                               wr_ready,
   output logic [HOST_ADDR_WIDTH-1:0]         wr_addr,
   output logic [RBB_DATA_WIDTH-1:0]          wr_data,
   output logic                               batch_done,
   output logic [$clog2(NUM_RBB)-1:0]         batch_id
);

   localparam int IDW = $clog2(NUM_RBB);
   localparam logic [RBB_ADDR_WIDTH-1:0] LAST_LINE = RBB_ADDR_WIDTH'(NUM_LINES - 1);

   typedef enum logic [1:0] {IDLE, READ, FLUSH} state_t;

   state_t                       r_state, w_nextState;
   logic [IDW-1:0]               r_lastGrant, r_batchId, w_grantIdx, w_cand;
   logic                         w_grantValid;
   logic [RBB_ADDR_WIDTH-1:0]    r_lineCnt;
   logic                         r_inFlight;
   logic [RBB_DATA_WIDTH-1:0]    r_fifoData [2];
   logic                         r_wrPtr, r_rdPtr;
   logic [1:0]                   r_count;
   logic [1:0]                   w_pending;
   logic [HOST_ADDR_WIDTH-1:0]   r_hostAddr;
   logic [RBB_DATA_WIDTH-1:0]    w_rdSlice;
   logic                         w_pop, w_issue;

   assign w_pop      = (r_count != 2'd0) && wr_ready;
   // Occupancy the FIFO will have after this cycle's pop and in-flight push;
   // counting the pop lets reads continue back-to-back while the host keeps up.
   assign w_pending  = r_count - {1'b0, w_pop} + {1'b0, r_inFlight};

   assign wr_valid   = (r_count != 2'd0);
   assign wr_data    = r_fifoData[r_rdPtr];
   assign wr_addr    = r_hostAddr;
   assign batch_id   = r_batchId;
   assign rbb_rdaddr = r_lineCnt;

   always_comb begin
      w_grantValid = 1'b0;
      w_grantIdx   = r_lastGrant;
      w_cand       = r_lastGrant;
      // Descending scan so the nearest requester after last grant wins
      for (int k = NUM_RBB; k >= 1; k--) begin
         w_cand = r_lastGrant + IDW'(k);
         if (rbb_request[w_cand]) begin
            w_grantValid = 1'b1;
            w_grantIdx   = w_cand;
         end
      end
   end

   always_comb begin
      w_rdSlice = '0;
      for (int i = 0; i < NUM_RBB; i++) begin
         if (r_batchId == IDW'(i)) w_rdSlice = rbb_rddout[i*RBB_DATA_WIDTH +: RBB_DATA_WIDTH];
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) r_state <= IDLE;
      else          r_state <= w_nextState;
   end

   always_comb begin
      w_nextState = r_state;
      w_issue     = 1'b0;
      rbb_rden    = '0;
      batch_done  = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_grantValid) w_nextState = READ;
         end
         READ: begin
            if (w_pending < 2'd2) begin
               w_issue  = 1'b1;
               rbb_rden = NUM_RBB'(1) << r_batchId;
               if (r_lineCnt == LAST_LINE) w_nextState = FLUSH;
            end
         end
         FLUSH: begin
            if (w_pop && (r_count == 2'd1) && !r_inFlight) begin
               batch_done  = 1'b1;
               w_nextState = IDLE;
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

   // Grant bookkeeping, read counter and output FIFO
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_lastGrant   <= '1;
         r_batchId     <= '0;
         r_lineCnt     <= '0;
         r_inFlight    <= 1'b0;
         r_fifoData[0] <= '0;
         r_fifoData[1] <= '0;
         r_wrPtr       <= 1'b0;
         r_rdPtr       <= 1'b0;
         r_count       <= 2'd0;
         r_hostAddr    <= base_addr;
      end else begin
         if ((r_state == IDLE) && w_grantValid) begin
            r_batchId   <= w_grantIdx;
            r_lastGrant <= w_grantIdx;
         end
         r_inFlight <= w_issue;
         if (w_issue) begin
            r_lineCnt <= (r_lineCnt == LAST_LINE) ? '0 : r_lineCnt + RBB_ADDR_WIDTH'(1);
         end
         if (r_inFlight) begin
            r_fifoData[r_wrPtr] <= w_rdSlice;
            r_wrPtr             <= ~r_wrPtr;
         end
         if (w_pop) begin
            r_rdPtr    <= ~r_rdPtr;
            r_hostAddr <= r_hostAddr + HOST_ADDR_WIDTH'(1);
         end
         r_count <= r_count + {1'b0, r_inFlight} - {1'b0, w_pop};
      end
   end

endmodule

// File: tb/tb_rbb_drain.sv
// Scoreboard bench for rbb_drain: stimulus queues expected host writes,
// a monitor compares every accepted write and every buffer read.
module tb_rbb_drain;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [3:0]    rbb_request;
   logic [3:0]    rbb_rden;
   logic [3:0]    rbb_rdaddr;
   logic [2047:0] rbb_rddout;
   logic [31:0]   base_addr = 32'h1000;
   logic          wr_valid;
   logic          wr_ready = 1'b1;
   logic [31:0]   wr_addr;
   logic [511:0]  wr_data;
   logic          batch_done;
   logic [1:0]    batch_id;

   typedef struct {
      logic [31:0]  addr;
      logic [511:0] data;
      logic         last;
      logic [1:0]   id;
   } exp_t;

   exp_t        sbq[$];
   int          total = 0;
   int          bad = 0;
   int          readsIssued = 0;
   int          writesAccepted = 0;
   int          expRd = 0;
   int          readyMode = 0;
   logic [3:0]  reqSet = 4'b0;
   logic [3:0]  reqNext;
   logic [31:0] expAddr;

   rbb_drain dut (
      .clk(clk), .reset_n(reset_n), .rbb_request(rbb_request), .rbb_rden(rbb_rden),
      .rbb_rdaddr(rbb_rdaddr), .rbb_rddout(rbb_rddout), .base_addr(base_addr),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
      .batch_done(batch_done), .batch_id(batch_id)
   );

   always #5 clk = ~clk;

   function automatic logic [511:0] lineData(input int b, input int l);
      logic [31:0] w;
      w = 32'hC0DE0000 | 32'(b << 8) | 32'(l);
      return {16{w}};
   endfunction

   // Buffer model: 1-cycle read latency, request dropped after the last line is read
   always @(posedge clk) begin
      if (!reset_n) begin
         rbb_request <= 4'b0;
      end else begin
         reqNext = rbb_request | reqSet;
         for (int i = 0; i < 4; i++) begin
            if (rbb_rden[i] && rbb_rdaddr == 4'd15) reqNext[i] = 1'b0;
         end
         rbb_request <= reqNext;
      end
      for (int i = 0; i < 4; i++) begin
         if (rbb_rden[i]) rbb_rddout[i*512 +: 512] <= lineData(i, int'(rbb_rdaddr));
      end
   end

   initial rbb_rddout = '0;

   // Host ready pattern: 0 = always high, 1 = random 30% high, 2 = held low
   initial forever begin
      @(posedge clk);
      #1;
      case (readyMode)
         0: wr_ready = 1'b1;
         1: wr_ready = ($urandom_range(0, 9) < 3);
         default: wr_ready = 1'b0;
      endcase
   end

   task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] mask);
      reqSet = mask;
      @(posedge clk);
      #1;
      reqSet = 4'b0;
   endtask

   task automatic expectBatch(input int b);
      exp_t e;
      for (int l = 0; l < 16; l++) begin
         e.addr = expAddr;
         e.data = lineData(b, l);
         e.last = (l == 15);
         e.id   = 2'(b);
         sbq.push_back(e);
         expAddr = expAddr + 32'd1;
      end
   endtask

   task automatic waitDrain(input int budget);
      int n;
      n = 0;
      while (sbq.size() != 0 && n < budget) begin
         @(posedge clk);
         n++;
      end
      repeat (3) @(posedge clk);
      total++;
      if (sbq.size() != 0) begin
         bad++;
         $display("[TB] FAIL drain_timeout: %0d lines left, expected 0", sbq.size());
         sbq.delete();
      end
   endtask

   task automatic doReset(input logic [31:0] base);
      @(posedge clk);
      #1;
      reset_n   = 1'b0;
      base_addr = base;
      sbq.delete();
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_wr_valid", wr_valid, 0);
      checkOutput("rst_rden", rbb_rden, 0);
      checkOutput("rst_rdaddr", rbb_rdaddr, 0);
      checkOutput("rst_wr_addr", wr_addr, base);
      checkOutput("rst_wr_data", wr_data, 0);
      checkOutput("rst_batch_done", batch_done, 0);
      checkOutput("rst_batch_id", batch_id, 0);
      reset_n = 1'b1;
      expAddr = base;
   endtask

   // Monitor: compares reads and accepted writes against the scoreboard
   initial forever begin
      exp_t e;
      @(negedge clk);
      if (!reset_n) begin
         readsIssued    = 0;
         writesAccepted = 0;
         expRd          = 0;
      end else begin
         if (rbb_rden != 4'b0) begin
            checkOutput("rden_onehot", $onehot(rbb_rden), 1);
            checkOutput("rd_addr", rbb_rdaddr, expRd);
            expRd = (expRd + 1) % 16;
            readsIssued++;
         end
         if (wr_valid && wr_ready) begin
            writesAccepted++;
            if (sbq.size() == 0) begin
               total++;
               bad++;
               $display("[TB] FAIL unexpected_write: addr %0h with empty scoreboard", wr_addr);
            end else begin
               e = sbq.pop_front();
               checkOutput("wr_addr", wr_addr, e.addr);
               checkOutput("wr_data", wr_data, e.data);
               checkOutput("batch_done", batch_done, e.last);
               if (e.last) checkOutput("batch_id", batch_id, e.id);
            end
         end else begin
            checkOutput("done_idle", batch_done, 0);
         end
         if (rbb_rden != 4'b0) checkOutput("outstanding_le2", (readsIssued - writesAccepted) <= 2, 1);
      end
   end

   initial begin
      int n;
      logic [31:0] stallAddr;
      int r0;

      doReset(32'h1000);

      // Single request to buffer 0
      applyStimulus(4'b0001);
      expectBatch(0);
      waitDrain(400);

      // All four at once; last grant was 0 so round-robin serves 1,2,3,0
      applyStimulus(4'b1111);
      expectBatch(1);
      expectBatch(2);
      expectBatch(3);
      expectBatch(0);
      waitDrain(800);

      // Random 30% host ready; last grant was 0 so buffer 2 is served
      readyMode = 1;
      applyStimulus(4'b0100);
      expectBatch(2);
      waitDrain(2000);
      readyMode = 0;

      // Host stalled for 100 cycles after the first read
      readyMode = 2;
      repeat (2) @(posedge clk);
      r0 = readsIssued;
      stallAddr = expAddr;
      applyStimulus(4'b1000);
      expectBatch(3);
      n = 0;
      while (readsIssued == r0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      repeat (100) @(negedge clk);
      checkOutput("stall_reads", readsIssued - r0, 2);
      checkOutput("stall_wr_valid", wr_valid, 1);
      checkOutput("stall_wr_addr", wr_addr, stallAddr);
      checkOutput("stall_wr_data", wr_data, lineData(3, 0));
      readyMode = 0;
      waitDrain(400);

      // Host address wrap
      doReset(32'hFFFF_FFF8);
      applyStimulus(4'b0010);
      expectBatch(1);
      waitDrain(400);

      // Reset while buffer 1 (second batch) is at line 7
      doReset(32'h2000);
      applyStimulus(4'b0011);
      expectBatch(0);
      expectBatch(1);
      n = 0;
      while (!(rbb_rden == 4'b0010 && rbb_rdaddr == 4'd7) && n < 200) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (n >= 200) begin
         bad++;
         $display("[TB] FAIL line7_timeout: waited %0d cycles, expected under 200", n);
      end
      @(posedge clk);
      #1;
      reset_n = 1'b0;
      sbq.delete();
      @(posedge clk);
      #1;
      checkOutput("abort_wr_valid", wr_valid, 0);
      checkOutput("abort_rden", rbb_rden, 0);
      checkOutput("abort_rdaddr", rbb_rdaddr, 0);
      checkOutput("abort_batch_done", batch_done, 0);
      doReset(32'h3000);
      applyStimulus(4'b0100);
      expectBatch(2);
      waitDrain(400);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
